cs_resolve_seq: RTL and testbench
=================================

// Module: cs_resolve_seq
// PURPOSE
//  Carry-save resolver at the output end of the multiplier's compressor tree.
//  Accepts the final sum/carry vector pair from the 4:2 compressor stage over a
//  valid/ready handshake. Resolves the pair into a binary result with a multi-cycle
//  carry-propagate addition, CHUNK bits per cycle. Holds the result until the consumer accepts it.
// PARAMETERS
//  WIDTH  16  width of sum_in, carry_in and result; must be a multiple of CHUNK
//  CHUNK  4   bits resolved per ADD cycle; 1 <= CHUNK <= WIDTH
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      sum_in/carry_in are valid
//  in_ready   out  1      block can capture an operand pair
//  sum_in     in   WIDTH  sum vector from the compressor tree
//  carry_in   in   WIDTH  carry vector, already left-aligned to its weight by the tree
//  out_valid  out  1      result/cout are valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  (sum_in + carry_in) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  busy       out  1      high in ADD or DONE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; result=0, cout=0, out_valid=0, busy=0, in_ready=1
//    once rst_n=1. Any in-flight operation is abandoned and never emitted.
//  - NSLICE = WIDTH/CHUNK. Slice k covers bits [k*CHUNK +: CHUNK].
//  - IDLE: in_ready=1.
//    - On in_valid&&in_ready: capture sum_in/carry_in into operand regs, clear result
//      and the running carry, set slice idx=0, go to ADD.
//  - ADD: in_ready=0, busy=1.
//    - Each cycle: {c,result[slice idx]} = sum[idx]+carry[idx]+running carry; store c; idx++.
//    - After slice NSLICE-1 is written: cout=c, go to DONE.
//  - DONE: out_valid=1; result and cout stay stable while out_ready=0.
//    - On out_ready: go to IDLE, out_valid=0 next cycle. result/cout keep their values until
//      the next capture.
//  - Latency: capture at edge E; out_valid is high after edge E+NSLICE. Throughput is one op
//    per NSLICE+2 cycles minimum (no capture during DONE).
//  - in_valid outside IDLE is ignored; the upstream holds its data, per the handshake rule.
//  - Wrap-around: result discards overflow; the overflow appears only on cout.
//    Example: 0xFFFF+0x0001 gives result=0x0000, cout=1.
//  - CHUNK==WIDTH: exactly one ADD cycle.
//  - Illegal parameter combos (WIDTH%CHUNK!=0) stop elaboration via a generate-time $error.
//  - The idx counter is $clog2(NSLICE) bits, minimum 1. It never exceeds NSLICE-1.
// STRUCTURE
//  - Shared package mul_pkg:
//    - state typedef {IDLE, ADD, DONE}, 2-bit encoding
//    - localparam helper for NSLICE/idx width
//  - One sub-module, chunk_adder: CHUNK-bit ripple adder built from fa_df full-adder
//    instances. Inputs a, b, cin. Outputs s, cout. Purely combinational; used once per cycle.
//  - Top level: FSM, operand regs, slice mux, result reg, running-carry flop.
// TESTING  (WIDTH=16, CHUNK=4 unless noted)
//  - Reset: drive rst_n=0 mid-cycle -> outputs 0 immediately (async); after release,
//    in_ready=1 and busy=0.
//  - Basic: sum=0x00FF, carry=0x0001 -> result=0x0100, cout=0; out_valid exactly 4 edges
//    after capture.
//  - Wrap: sum=0xFFFF, carry=0x0001 -> result=0x0000, cout=1.
//    Also sum=0x8000, carry=0x8000 -> 0x0000, cout=1.
//  - Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new data ->
//    result/cout/out_valid stable, in_ready=0, new data not captured. The new data is
//    captured only after out_ready and return to IDLE.
//  - Reset mid-ADD: assert rst_n=0 when idx=2 -> IDLE, out_valid=0. The next op
//    sum=0x1234, carry=0x4321 -> result=0x5555, cout=0.
//  - Random: 1000 ops vs reference model (sum+carry) with random in_valid/out_ready gaps.
//    Repeat with CHUNK=1 (16 ADD cycles) and CHUNK=16 (1 ADD cycle).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the multiplier's carry-save resolver.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // The slice counter keeps at least one bit, even when there is only one slice.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from dataflow full adders.
module fa_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa_df u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];
endmodule

// File: rtl/cs_resolve_seq.sv
// Resolves a carry-save sum/carry pair into binary, CHUNK bits per cycle,
// holding the result until the consumer accepts it.
module cs_resolve_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = nslice_of(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("cs_resolve_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, carry_q, result_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_run_q, cout_q;
  logic [CHUNK-1:0]   a_slice, b_slice, s_slice;
  logic               c_slice;

  always_comb begin
    a_slice = sum_q[int'(idx_q)*CHUNK +: CHUNK];
    b_slice = carry_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a   (a_slice),
    .b   (b_slice),
    .cin (carry_run_q),
    .s   (s_slice),
    .cout(c_slice)
  );

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: operand registers are reset along with the visible outputs; they are few flops, and it keeps the slice mux free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      carry_run_q <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sum_q       <= sum_in;
          carry_q     <= carry_in;
          result_q    <= '0;
          idx_q       <= '0;
          carry_run_q <= 1'b0;
          cout_q      <= 1'b0;
        end
        ADD: begin
          result_q[int'(idx_q)*CHUNK +: CHUNK] <= s_slice;
          carry_run_q <= c_slice;
          // The counter parks on the last slice so it never exceeds NSLICE-1.
          if (idx_q == LAST_IDX) cout_q <= c_slice;
          else                   idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
endmodule

// File: tb/tb_cs_resolve_seq.sv
// Scoreboard bench for cs_resolve_seq: three lanes (CHUNK 4, 1, 16) with directed and random traffic.
module tb_cs_resolve_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int NS = 16 / CH;

    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] sum_in    = '0;
    logic [15:0] carry_in  = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] result;
    bit          done = 1'b0;

    cs_resolve_seq #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum_in   (sum_in),
      .carry_in (carry_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .cout     (cout),
      .busy     (busy)
    );

    // Reference: the full 17-bit integer sum; bit 16 is the expected carry out.
    logic [16:0] exp_q[$];
    int          cap_q[$];
    int          cyc = 0;
    bit          prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tag(input string s);
      return $sformatf("chunk%0d %s", CH, s);
    endfunction

    always @(negedge clk) begin : mon
      logic [16:0] e;
      int          c0;
      if (!rst_n) begin
        exp_q.delete();
        cap_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (cap_q.size() == 0) check(tag("out_valid without capture"), 1, 0);
          else begin
            c0 = cap_q.pop_front();
            check(tag("latency"), cyc - c0, NS + 1);
          end
        end
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check(tag("unexpected result"), 1, 0);
          else begin
            e = exp_q.pop_front();
            check(tag("result+cout"), {cout, result}, e);
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back({1'b0, sum_in} + {1'b0, carry_in});
          cap_q.push_back(cyc);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] c);
      int n = 0;
      sum_in   = s;
      carry_in = c;
      in_valid = 1'b1;
      while (!in_ready && n < 500) begin tick(); n++; end
      if (!in_ready) check(tag("send timeout"), 0, 1);
      tick();
      in_valid = 1'b0;
    endtask

    task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 500) begin tick(); n++; end
      if (!out_valid) check(tag("out_valid timeout"), 0, 1);
    endtask

    task automatic recv();
      out_ready = 1'b1;
      wait_valid();
      tick();
      out_ready = 1'b0;
    endtask

    initial begin : seq
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check(tag("reset in_ready"), in_ready, 1);
      check(tag("reset busy"), busy, 0);
      check(tag("reset out_valid"), out_valid, 0);

      // Basic op, then an asynchronous reset while the result is held.
      send(16'h00FF, 16'h0001);
      wait_valid();
      check(tag("basic result"), result, 16'h0100);
      check(tag("basic cout"), cout, 0);
      #1 rst_n = 1'b0;
      #1;
      check(tag("async out_valid"), out_valid, 0);
      check(tag("async busy"), busy, 0);
      check(tag("async result"), result, 0);
      check(tag("async cout"), cout, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check(tag("release in_ready"), in_ready, 1);
      check(tag("release busy"), busy, 0);

      // Wrap-around cases.
      send(16'hFFFF, 16'h0001);
      recv();
      send(16'h8000, 16'h8000);
      recv();

      // Backpressure: new data offered while the result is held.
      send(16'h1111, 16'h2222);
      wait_valid();
      sum_in   = 16'hAAAA;
      carry_in = 16'h5555;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        check(tag("hold out_valid"), out_valid, 1);
        check(tag("hold in_ready"), in_ready, 0);
        check(tag("hold result"), result, 16'h3333);
        check(tag("hold cout"), cout, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check(tag("after accept in_ready"), in_ready, 1);
      tick();
      in_valid = 1'b0;
      recv();

      // Reset while ADD is in progress, then a clean op.
      send(16'hFFFF, 16'hFFFF);
      repeat ((NS > 2) ? 2 : 0) tick();
      #1 rst_n = 1'b0;
      #1;
      check(tag("midadd out_valid"), out_valid, 0);
      check(tag("midadd busy"), busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check(tag("midadd in_ready"), in_ready, 1);
      send(16'h1234, 16'h4321);
      wait_valid();
      check(tag("post-reset result"), result, 16'h5555);
      check(tag("post-reset cout"), cout, 0);
      recv();

      // Random traffic with independent producer and consumer gaps.
      fork
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          send(16'($urandom()), 16'($urandom()));
        end
        for (int j = 0; j < 1000; j++) begin
          repeat ($urandom_range(0, 3)) tick();
          recv();
        end
      join
      repeat (2) tick();
      check(tag("scoreboard drained"), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done && lane[2].done);
      begin
        #900000;
        $display("FAIL global timeout: lanes still running");
        n_checks++;
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
